rgen_apb_master_bridge: RTL and testbench
=========================================

# rgen_apb_master_bridge

Converts a simple valid/ready host command stream into APB4 master transactions driving a generated register block's APB slave port (`i_paddr` … `o_pslverr`). Sits directly upstream of a register block. Returns each access result as a valid/ready response carrying read data and a 2-bit status. Handles one transaction at a time, with an optional ACCESS-phase timeout.

## Interface
- `ADDRESS_WIDTH`, 16, width of request address and `o_paddr`
- `DATA_WIDTH`, 32, data width; must be 8, 16, 32 or 64
- `TIMEOUT_CYCLES`, 255, maximum ACCESS-phase cycles before abort; must be ≥1; used only with timeout compiled in
- `clk` in 1 — clock
- `rst_n` in 1 — asynchronous active-low reset
- `i_request_valid` in 1 — request present
- `o_request_ready` out 1 — bridge accepts request
- `i_request_write` in 1 — 1 = write, 0 = read
- `i_request_address` in ADDRESS_WIDTH — byte address
- `i_request_write_data` in DATA_WIDTH — write data
- `i_request_strobe` in DATA_WIDTH/8 — byte enables, writes only
- `o_response_valid` out 1 — response present
- `i_response_ready` in 1 — response consumed
- `o_response_read_data` out DATA_WIDTH — read data; 0 for writes and errors
- `o_response_status` out 2 — 2'b00 OK, 2'b01 SLVERR, 2'b10 TIMEOUT
- `o_paddr` out ADDRESS_WIDTH; `o_pprot` out 3 (constant 3'b000); `o_psel` out 1; `o_penable` out 1; `o_pwrite` out 1; `o_pwdata` out DATA_WIDTH; `o_pstrb` out DATA_WIDTH/8
- `i_pready` in 1; `i_prdata` in DATA_WIDTH; `i_pslverr` in 1

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESPONSE.
- **IDLE**
  - `o_request_ready`=1.
  - On `i_request_valid`: register address, write, data and strobe into the APB output registers, then go to SETUP.
  - For reads, `o_pstrb` is forced to 0.
- **SETUP**
  - `o_psel`=1, `o_penable`=0.
  - Always goes to ACCESS next cycle.
- **ACCESS**
  - `o_psel`=1, `o_penable`=1.
  - When `i_pready`=1:
    - Capture `i_prdata` (reads only, and only if `i_pslverr`=0); otherwise capture 0.
    - Status = `i_pslverr` ? 01 : 00.
    - Go to RESPONSE.
- **RESPONSE**
  - `o_psel`=`o_penable`=0, `o_response_valid`=1.
  - Response fields hold stable until `i_response_ready`=1, then go to IDLE.
- `o_request_ready` is 0 in every state except IDLE. No request pipelining.
- `o_paddr`, `o_pwrite`, `o_pwdata` and `o_pstrb` hold their values from acceptance until the next acceptance. They are stable throughout SETUP and ACCESS.
- `i_pslverr` and `i_prdata` are sampled only in the cycle where ACCESS and `i_pready` are both high.
- **Reset** (asynchronous, any state):
  - State returns to IDLE.
  - `o_psel`, `o_penable`, `o_response_valid` = 0.
  - `o_paddr`, `o_pwdata`, `o_pstrb`, `o_pwrite`, `o_response_read_data`, `o_response_status` = 0.
  - `o_request_ready` = 1 once reset is released.
  - An in-flight transaction is dropped with no response.

## Timing
- Request accepted at rising edge N.
- SETUP during cycle N+1; ACCESS from cycle N+2.
- With `i_pready` high in the first ACCESS cycle, `o_response_valid` rises in cycle N+3.
- With `i_response_ready` held high, `o_request_ready` returns in cycle N+4. Maximum throughput is one transaction per 4 cycles.
- Each slave wait state (`i_pready`=0 in ACCESS) adds one cycle.
- All outputs are registered. No combinational path exists from any input to any output except `o_request_ready`, which is decoded from state only.

## Configuration
- `RGEN_APB_MASTER_BRIDGE_TIMEOUT_EN` defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with `i_pready`=0.
  - When the count reaches TIMEOUT_CYCLES with `i_pready` still 0, the bridge aborts: `o_psel`/`o_penable` drop next cycle, read data = 0, status = 10, and the FSM goes to RESPONSE.
  - `i_pready` arriving in the same cycle as expiry wins, and the transaction completes normally.
- Not defined:
  - No counter is built.
  - ACCESS waits indefinitely.
  - Status 10 is never produced.

## Test plan
- Write 0x0004 ← 0x12345678 with strobe 0xF, `i_pready`=1 immediately. Expect:
  - `o_psel` for 2 cycles, `o_penable` in the second.
  - `o_pwdata`=0x12345678, `o_pstrb`=0xF.
  - Response status 00, data 0, response valid at N+3.
- Read 0x0008 with `i_prdata`=0xDEADBEEF and 3 wait states. Expect:
  - ACCESS lasts 4 cycles, `o_pstrb`=0.
  - Response data 0xDEADBEEF, status 00, response valid at N+6.
- Read with `i_pslverr`=1 at completion. Expect status 01, read data 0, `o_psel` low in the RESPONSE cycle.
- Hold `i_response_ready`=0 for 5 cycles. Expect:
  - Response fields stable throughout.
  - `o_request_ready`=0 throughout, and a second `i_request_valid` is not accepted.
  - The second request is accepted the cycle after the handshake.
- With the TIMEOUT macro defined and TIMEOUT_CYCLES=4, `i_pready` held 0. Expect:
  - Abort after 4 ACCESS cycles, status 10, data 0.
  - A following request proceeds normally.
  - Repeat with `i_pready` rising exactly on the expiry cycle: expect status 00.
- Assert `rst_n`=0 during ACCESS. Expect `o_psel`/`o_penable`/`o_response_valid` to go 0 immediately (asynchronously), no response after release, and `o_request_ready`=1.

Source files
------------

// File: rtl/rgen_apb_master_bridge.sv
// rgen_apb_master_bridge
// Turns a valid/ready host command stream into single APB4 master transfers
// and returns each result as a valid/ready response (read data + 2-bit status).
// One transfer in flight at a time: IDLE -> SETUP -> ACCESS -> RESPONSE.
// Optional ACCESS-phase timeout: define RGEN_APB_MASTER_BRIDGE_TIMEOUT_EN.
// Without it, ACCESS waits for i_pready indefinitely.

module rgen_apb_master_bridge #(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // host request
    input  logic                      i_request_valid,
    output logic                      o_request_ready,
    input  logic                      i_request_write,
    input  logic [ADDRESS_WIDTH-1:0]  i_request_address,
    input  logic [DATA_WIDTH-1:0]     i_request_write_data,
    input  logic [DATA_WIDTH/8-1:0]   i_request_strobe,
    // host response
    output logic                      o_response_valid,
    input  logic                      i_response_ready,
    output logic [DATA_WIDTH-1:0]     o_response_read_data,
    output logic [1:0]                o_response_status,
    // APB4 master
    output logic [ADDRESS_WIDTH-1:0]  o_paddr,
    output logic [2:0]                o_pprot,
    output logic                      o_psel,
    output logic                      o_penable,
    output logic                      o_pwrite,
    output logic [DATA_WIDTH-1:0]     o_pwdata,
    output logic [DATA_WIDTH/8-1:0]   o_pstrb,
    input  logic                      i_pready,
    input  logic [DATA_WIDTH-1:0]     i_prdata,
    input  logic                      i_pslverr
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] STATUS_OK      = 2'b00;
    localparam logic [1:0] STATUS_SLVERR  = 2'b01;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

    // Elaboration-time parameter sanity checks.
    if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_data_width
        $error("rgen_apb_master_bridge: DATA_WIDTH must be 8, 16, 32 or 64");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("rgen_apb_master_bridge: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        ACCESS   = 2'd2,
        RESPONSE = 2'd3
    } state_t;

    state_t                    state_reg;
    state_t                    state_next;

    logic [ADDRESS_WIDTH-1:0]  paddr_reg;
    logic                      pwrite_reg;
    logic [DATA_WIDTH-1:0]     pwdata_reg;
    logic [STRB_WIDTH-1:0]     pstrb_reg;
    logic                      psel_reg;
    logic                      penable_reg;
    logic                      response_valid_reg;
    logic [DATA_WIDTH-1:0]     response_read_data_reg;
    logic [1:0]                response_status_reg;

    logic                      accept;
    logic                      complete;
    logic                      timeout_hit;

    assign accept   = (state_reg == IDLE) && i_request_valid;
    assign complete = (state_reg == ACCESS) && i_pready;

`ifdef RGEN_APB_MASTER_BRIDGE_TIMEOUT_EN
    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_WIDTH-1:0] wait_count_reg;

    // Count stalled ACCESS cycles; held at zero outside ACCESS so each entry starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_count_reg <= '0;
        end else if (state_reg != ACCESS) begin
            wait_count_reg <= '0;
        end else if (!i_pready) begin
            wait_count_reg <= wait_count_reg + 1'b1;
        end
    end

    // Expiry fires in the ACCESS cycle whose stall brings the count to TIMEOUT_CYCLES;
    // a simultaneous i_pready takes priority and completes the transfer normally.
    assign timeout_hit = (state_reg == ACCESS) && !i_pready &&
                         (wait_count_reg == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (i_request_valid) state_next = SETUP;
            SETUP:    state_next = ACCESS;
            ACCESS:   if (i_pready || timeout_hit) state_next = RESPONSE;
            RESPONSE: if (i_response_ready) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // APB request fields: loaded on acceptance, held until the next acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            paddr_reg  <= '0;
            pwrite_reg <= 1'b0;
            pwdata_reg <= '0;
            pstrb_reg  <= '0;
        end else if (accept) begin
            paddr_reg  <= i_request_address;
            pwrite_reg <= i_request_write;
            pwdata_reg <= i_request_write_data;
            pstrb_reg  <= i_request_write ? i_request_strobe : '0;
        end
    end

    // APB control and response-valid registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psel_reg           <= 1'b0;
            penable_reg        <= 1'b0;
            response_valid_reg <= 1'b0;
        end else begin
            psel_reg           <= (state_next == SETUP) || (state_next == ACCESS);
            penable_reg        <= (state_next == ACCESS);
            response_valid_reg <= (state_next == RESPONSE);
        end
    end

    // Response payload: captured at completion or abort, stable through RESPONSE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            response_read_data_reg <= '0;
            response_status_reg    <= STATUS_OK;
        end else if (complete) begin
            response_read_data_reg <= (!pwrite_reg && !i_pslverr) ? i_prdata : '0;
            response_status_reg    <= i_pslverr ? STATUS_SLVERR : STATUS_OK;
        end else if (timeout_hit) begin
            response_read_data_reg <= '0;
            response_status_reg    <= STATUS_TIMEOUT;
        end
    end

    assign o_request_ready      = (state_reg == IDLE);
    assign o_response_valid     = response_valid_reg;
    assign o_response_read_data = response_read_data_reg;
    assign o_response_status    = response_status_reg;
    assign o_paddr              = paddr_reg;
    assign o_pprot              = 3'b000;
    assign o_psel               = psel_reg;
    assign o_penable            = penable_reg;
    assign o_pwrite             = pwrite_reg;
    assign o_pwdata             = pwdata_reg;
    assign o_pstrb              = pstrb_reg;

endmodule

// File: tb/tb_rgen_apb_master_bridge.sv
// Directed testbench for rgen_apb_master_bridge (TIMEOUT_CYCLES=4).
// Timeout scenarios run when RGEN_APB_MASTER_BRIDGE_TIMEOUT_EN is defined;
// otherwise the bench checks that a long stall still completes with status 00.

module tb_rgen_apb_master_bridge;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_status;
    logic [15:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    int total = 0;
    int bad   = 0;

    rgen_apb_master_bridge #(
        .ADDRESS_WIDTH  (16),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .i_request_valid      (req_valid),
        .o_request_ready      (req_ready),
        .i_request_write      (req_write),
        .i_request_address    (req_addr),
        .i_request_write_data (req_wdata),
        .i_request_strobe     (req_strb),
        .o_response_valid     (resp_valid),
        .i_response_ready     (resp_ready),
        .o_response_read_data (resp_rdata),
        .o_response_status    (resp_status),
        .o_paddr              (paddr),
        .o_pprot              (pprot),
        .o_psel               (psel),
        .o_penable            (penable),
        .o_pwrite             (pwrite),
        .o_pwdata             (pwdata),
        .o_pstrb              (pstrb),
        .i_pready             (pready),
        .i_prdata             (prdata),
        .i_pslverr            (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction with i_response_ready held high. The slave answers in
    // ACCESS cycle waits+1; prdata/pslverr carry junk until then.
    task automatic run_txn(
        input  logic        wr,
        input  logic [15:0] addr,
        input  logic [31:0] wd,
        input  logic [3:0]  st,
        input  int          waits,
        input  logic [31:0] rd,
        input  logic        err,
        output int          lat,
        output int          acc,
        output logic [1:0]  status,
        output logic [31:0] rdata,
        output logic [15:0] s_paddr,
        output logic [31:0] s_pwdata,
        output logic [3:0]  s_pstrb,
        output logic        s_pwrite,
        output logic [1:0]  s_selen,
        output logic        r_selen,
        output logic        ready_after
    );
        lat = 0;
        acc = 0;
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wd;
        req_strb   = st;
        resp_ready = 1'b1;
        pready     = 1'b0;
        pslverr    = 1'b1;
        prdata     = 32'hBAD0_BAD0;
        tick();
        lat = 1;
        // Scramble request inputs to prove the APB fields are held.
        req_valid = 1'b0;
        req_write = ~wr;
        req_addr  = 16'hFFFF;
        req_wdata = 32'hFFFF_FFFF;
        req_strb  = 4'hF;
        s_paddr   = paddr;
        s_pwdata  = pwdata;
        s_pstrb   = pstrb;
        s_pwrite  = pwrite;
        s_selen   = {psel, penable};
        while (!resp_valid && lat < 100) begin
            if (psel && penable) begin
                acc++;
                if (acc > waits) begin
                    pready  = 1'b1;
                    prdata  = rd;
                    pslverr = err;
                end else begin
                    pready  = 1'b0;
                    prdata  = 32'hBAD0_BAD0;
                    pslverr = 1'b1;
                end
            end else begin
                pready = 1'b0;
            end
            tick();
            lat++;
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 32'h0;
        status  = resp_status;
        rdata   = resp_rdata;
        r_selen = psel | penable;
        tick();
        ready_after = req_ready;
        $display("txn %s addr=%04h lat=%0d access=%0d status=%0b rdata=%08h",
                 wr ? "WR" : "RD", addr, lat, acc, status, rdata);
    endtask

    int          lat, acc;
    logic [1:0]  status;
    logic [31:0] rdata;
    logic [15:0] s_paddr;
    logic [31:0] s_pwdata;
    logic [3:0]  s_pstrb;
    logic        s_pwrite;
    logic [1:0]  s_selen;
    logic        r_selen;
    logic        ready_after;
    int          seen;

    initial begin
        rst_n      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 16'h0;
        req_wdata  = 32'h0;
        req_strb   = 4'h0;
        resp_ready = 1'b1;
        pready     = 1'b0;
        prdata     = 32'h0;
        pslverr    = 1'b0;

        // ---- reset state ----
        #1 rst_n = 1'b0;
        #1;
        chk("rst_psel",    psel,        1'b0);
        chk("rst_penable", penable,     1'b0);
        chk("rst_rvalid",  resp_valid,  1'b0);
        chk("rst_paddr",   paddr,       16'h0);
        chk("rst_pwdata",  pwdata,      32'h0);
        chk("rst_pstrb",   pstrb,       4'h0);
        chk("rst_pwrite",  pwrite,      1'b0);
        chk("rst_rdata",   resp_rdata,  32'h0);
        chk("rst_status",  resp_status, 2'b00);
        chk("rst_pprot",   pprot,       3'b000);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_req_ready", req_ready, 1'b1);

        // ---- write, zero wait states ----
        run_txn(1'b1, 16'h0004, 32'h1234_5678, 4'hF, 0, 32'h0, 1'b0,
                lat, acc, status, rdata, s_paddr, s_pwdata, s_pstrb, s_pwrite, s_selen, r_selen, ready_after);
        chk("wr_setup_selen", s_selen,  2'b10);
        chk("wr_paddr",       s_paddr,  16'h0004);
        chk("wr_pwdata",      s_pwdata, 32'h1234_5678);
        chk("wr_pstrb",       s_pstrb,  4'hF);
        chk("wr_pwrite",      s_pwrite, 1'b1);
        chk("wr_latency",     lat,      3);
        chk("wr_access",      acc,      1);
        chk("wr_status",      status,   2'b00);
        chk("wr_rdata",       rdata,    32'h0);
        chk("wr_resp_psel",   r_selen,  1'b0);
        chk("wr_ready_after", ready_after, 1'b1);
        chk("wr_held_paddr",  paddr,    16'h0004);

        // ---- read, three wait states ----
        run_txn(1'b0, 16'h0008, 32'hAAAA_5555, 4'hF, 3, 32'hDEAD_BEEF, 1'b0,
                lat, acc, status, rdata, s_paddr, s_pwdata, s_pstrb, s_pwrite, s_selen, r_selen, ready_after);
        chk("rd_paddr",   s_paddr,  16'h0008);
        chk("rd_pstrb",   s_pstrb,  4'h0);
        chk("rd_pwrite",  s_pwrite, 1'b0);
        chk("rd_latency", lat,      6);
        chk("rd_access",  acc,      4);
        chk("rd_status",  status,   2'b00);
        chk("rd_rdata",   rdata,    32'hDEAD_BEEF);

        // ---- read with slave error ----
        run_txn(1'b0, 16'h000C, 32'h0, 4'h3, 1, 32'h5A5A_5A5A, 1'b1,
                lat, acc, status, rdata, s_paddr, s_pwdata, s_pstrb, s_pwrite, s_selen, r_selen, ready_after);
        chk("err_latency",   lat,     4);
        chk("err_status",    status,  2'b01);
        chk("err_rdata",     rdata,   32'h0);
        chk("err_resp_psel", r_selen, 1'b0);

        // ---- write with partial strobe, slave error ----
        run_txn(1'b1, 16'h0010, 32'hCAFE_0001, 4'h5, 0, 32'h7777_7777, 1'b1,
                lat, acc, status, rdata, s_paddr, s_pwdata, s_pstrb, s_pwrite, s_selen, r_selen, ready_after);
        chk("wr5_pstrb",  s_pstrb, 4'h5);
        chk("wr5_status", status,  2'b01);
        chk("wr5_rdata",  rdata,   32'h0);

        // ---- response backpressure for 5 cycles ----
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 16'h0020;
        req_strb   = 4'h0;
        resp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        pready    = 1'b1;
        prdata    = 32'hCAFE_F00D;
        pslverr   = 1'b0;
        tick();
        tick();
        pready    = 1'b0;
        prdata    = 32'h0;
        // Second request presented while the response is stalled.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h0030;
        req_wdata = 32'h0BAD_F00D;
        req_strb  = 4'hF;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rvalid",    resp_valid,  1'b1);
            chk("bp_rdata",     resp_rdata,  32'hCAFE_F00D);
            chk("bp_status",    resp_status, 2'b00);
            chk("bp_req_ready", req_ready,   1'b0);
            chk("bp_psel",      psel,        1'b0);
            chk("bp_paddr",     paddr,       16'h0020);
            tick();
        end
        $display("txn RD addr=0020 held %0d cycles rdata=%08h", 5, resp_rdata);
        resp_ready = 1'b1;
        tick();
        chk("bp_rvalid_done",  resp_valid, 1'b0);
        chk("bp_ready_back",   req_ready,  1'b1);
        chk("bp_not_accepted", psel,       1'b0);
        tick();
        chk("bp2_psel",  psel,  1'b1);
        chk("bp2_paddr", paddr, 16'h0030);
        req_valid = 1'b0;
        pready    = 1'b1;
        tick();
        tick();
        pready = 1'b0;
        chk("bp2_rvalid", resp_valid,  1'b1);
        chk("bp2_status", resp_status, 2'b00);
        tick();
        $display("txn WR addr=0030 after backpressure status=%0b", resp_status);

`ifdef RGEN_APB_MASTER_BRIDGE_TIMEOUT_EN
        // ---- timeout abort ----
        run_txn(1'b0, 16'h0040, 32'h0, 4'h0, 1000, 32'h1111_1111, 1'b0,
                lat, acc, status, rdata, s_paddr, s_pwdata, s_pstrb, s_pwrite, s_selen, r_selen, ready_after);
        chk("to_latency", lat,     6);
        chk("to_access",  acc,     4);
        chk("to_status",  status,  2'b10);
        chk("to_rdata",   rdata,   32'h0);
        chk("to_psel",    r_selen, 1'b0);
        // ---- following request proceeds normally ----
        run_txn(1'b0, 16'h0044, 32'h0, 4'h0, 0, 32'h2222_2222, 1'b0,
                lat, acc, status, rdata, s_paddr, s_pwdata, s_pstrb, s_pwrite, s_selen, r_selen, ready_after);
        chk("to_next_status", status, 2'b00);
        chk("to_next_rdata",  rdata,  32'h2222_2222);
        // ---- pready on the expiry cycle wins ----
        run_txn(1'b0, 16'h0048, 32'h0, 4'h0, 3, 32'h3333_3333, 1'b0,
                lat, acc, status, rdata, s_paddr, s_pwdata, s_pstrb, s_pwrite, s_selen, r_selen, ready_after);
        chk("to_race_access", acc,    4);
        chk("to_race_status", status, 2'b00);
        chk("to_race_rdata",  rdata,  32'h3333_3333);
`else
        // ---- long stall completes normally without a timeout ----
        run_txn(1'b0, 16'h0040, 32'h0, 4'h0, 10, 32'h1111_1111, 1'b0,
                lat, acc, status, rdata, s_paddr, s_pwdata, s_pstrb, s_pwrite, s_selen, r_selen, ready_after);
        chk("stall_latency", lat,    13);
        chk("stall_access",  acc,    11);
        chk("stall_status",  status, 2'b00);
        chk("stall_rdata",   rdata,  32'h1111_1111);
`endif

        // ---- asynchronous reset during ACCESS ----
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h0050;
        pready    = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        chk("ar_in_access", {psel, penable}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_psel",      psel,       1'b0);
        chk("ar_penable",   penable,    1'b0);
        chk("ar_rvalid",    resp_valid, 1'b0);
        chk("ar_paddr",     paddr,      16'h0);
        #3 rst_n = 1'b1;
        pready = 1'b1;
        seen   = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (resp_valid || psel) seen++;
        end
        pready = 1'b0;
        chk("ar_no_response", seen,      0);
        chk("ar_req_ready",   req_ready, 1'b1);
        $display("txn RD addr=0050 dropped by reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
